fp_adder: RTL and testbench

FP_ADDER -- requirements
Module: fp_adder

---
 rtl/fp_adder.sv | 149 ++++++++++++++
 tb/tb_fp_adder.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/fp_adder.sv
// Pipelined IEEE-754 binary32 adder, round-to-nearest-even.
// Input register plus three compute stages; flush-to-zero on denormals.
module fp_adder (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result
);

  typedef struct packed {
    logic        spec;
    logic [31:0] sval;
    logic        sx;
    logic        sub;
    logic [7:0]  ex;
    logic [7:0]  diff;
    logic [23:0] mx;
    logic [23:0] my;
  } s1_t;

  typedef struct packed {
    logic        spec;
    logic [31:0] sval;
    logic        sx;
    logic        sub;
    logic [7:0]  ex;
    logic [27:0] sum;
  } s2_t;

  logic [31:0] a_q, b_q;
  s1_t         s1_d, s1_q;
  s2_t         s2_d, s2_q;
  logic [31:0] res_d, res_q;

  logic [7:0]  ea, eb, ey;
  logic        za, zb, ia, ib, na, nb, swap;
  logic [31:0] x, y;

  // Stage 1: unpack, specials, swap so |x| >= |y|, exponent difference.
  always_comb begin
    ea   = a_q[30:23];
    eb   = b_q[30:23];
    za   = (ea == 8'd0);
    zb   = (eb == 8'd0);
    ia   = (ea == 8'hFF) && (a_q[22:0] == 23'd0);
    ib   = (eb == 8'hFF) && (b_q[22:0] == 23'd0);
    na   = (ea == 8'hFF) && (a_q[22:0] != 23'd0);
    nb   = (eb == 8'hFF) && (b_q[22:0] != 23'd0);
    swap = (za ? 31'd0 : a_q[30:0]) < (zb ? 31'd0 : b_q[30:0]);
    x    = swap ? b_q : a_q;
    y    = swap ? a_q : b_q;
    ey   = y[30:23];
    s1_d = '0;
    s1_d.sx   = x[31];
    s1_d.sub  = x[31] ^ y[31];
    s1_d.ex   = x[30:23];
    s1_d.diff = x[30:23] - ey;
    s1_d.mx   = (x[30:23] == 8'd0) ? 24'd0 : {1'b1, x[22:0]};
    s1_d.my   = (ey == 8'd0) ? 24'd0 : {1'b1, y[22:0]};
    s1_d.spec = na | nb | ia | ib;
    if (na | nb | (ia & ib & (a_q[31] ^ b_q[31])))
      s1_d.sval = 32'h7FC0_0000;
    else if (ia)
      s1_d.sval = {a_q[31], 8'hFF, 23'd0};
    else if (ib)
      s1_d.sval = {b_q[31], 8'hFF, 23'd0};
  end

  logic [26:0] yext, yal, lost;

  // Stage 2: align y with guard/round/sticky, then magnitude add/sub.
  always_comb begin
    yext = {s1_q.my, 3'b000};
    lost = '0;
    if (s1_q.diff >= 8'd26) begin
      yal = {26'd0, |s1_q.my};
    end else begin
      yal    = yext >> s1_q.diff;
      lost   = yext & ~(27'h7FF_FFFF << s1_q.diff);
      yal[0] = yal[0] | (|lost);
    end
    s2_d      = '0;
    s2_d.spec = s1_q.spec;
    s2_d.sval = s1_q.sval;
    s2_d.sx   = s1_q.sx;
    s2_d.sub  = s1_q.sub;
    s2_d.ex   = s1_q.ex;
    if (s1_q.sub)
      s2_d.sum = {1'b0, s1_q.mx, 3'b000} - {1'b0, yal};
    else
      s2_d.sum = {1'b0, s1_q.mx, 3'b000} + {1'b0, yal};
  end

  logic [26:0] n;
  logic [4:0]  lz;
  logic [9:0]  e, e2;
  logic [24:0] mr;
  logic [22:0] frac;
  logic        inc;

  // Stage 3: normalize, round to nearest even, pack with range checks.
  always_comb begin
    lz = '0;
    for (int i = 0; i < 27; i++)
      if (s2_q.sum[i]) lz = 5'(26 - i);
    if (s2_q.sum[27]) begin
      n = {s2_q.sum[27:2], |s2_q.sum[1:0]};
      e = {2'b00, s2_q.ex} + 10'd1;
    end else begin
      n = s2_q.sum[26:0] << lz;
      e = {2'b00, s2_q.ex} - {5'd0, lz};
    end
    inc  = n[2] & (n[3] | n[1] | n[0]);
    mr   = {1'b0, n[26:3]} + {24'd0, inc};
    frac = mr[24] ? mr[23:1] : mr[22:0];
    e2   = e + {9'd0, mr[24]};
    if (s2_q.spec)
      res_d = s2_q.sval;
    else if (s2_q.sum == 28'd0)
      res_d = {s2_q.sx & ~s2_q.sub, 31'd0};
    else if ($signed(e2) <= 10'sd0)
      res_d = {s2_q.sx, 31'd0};
    else if ($signed(e2) >= 10'sd255)
      res_d = {s2_q.sx, 8'hFF, 23'd0};
    else
      res_d = {s2_q.sx, e2[7:0], frac};
  end

  // Pipeline registers; reset drops everything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      s1_q  <= '0;
      s2_q  <= '0;
      res_q <= '0;
    end else begin
      a_q   <= a;
      b_q   <= b;
      s1_q  <= s1_d;
      s2_q  <= s2_d;
      res_q <= res_d;
    end
  end

  assign result = res_q;

endmodule

// File: tb/tb_fp_adder.sv
// Scoreboard bench for fp_adder: directed vectors, expected sums queued
// with their due cycle and checked by an independent monitor.
module tb_fp_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] a, b, result;

  fp_adder dut (
    .clk    (clk),
    .rst    (rst),
    .a      (a),
    .b      (b),
    .result (result)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    int          due;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic expect_at(input int due, input logic [31:0] v,
                           input string nm);
    exp_t t;
    t.due  = due;
    t.val  = v;
    t.name = nm;
    q.push_back(t);
  endtask

  task automatic issue(input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] r, input string nm);
    a = x;
    b = y;
    expect_at(cyc + 4, r, nm);
    step();
  endtask

  // Monitor: compare every expectation that falls due this cycle.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].due <= cyc) begin
      n_chk++;
      if (q[0].due != cyc || result !== q[0].val) begin
        n_fail++;
        $display("FAIL %s: result=%h expected=%h (cycle %0d, due %0d)",
                 q[0].name, result, q[0].val, cyc, q[0].due);
      end
      void'(q.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    a   = '0;
    b   = '0;
    step();
    expect_at(cyc + 1, 32'h0, "reset_state");
    step();
    rst = 1'b0;
    expect_at(cyc + 1, 32'h0, "post_reset0");
    expect_at(cyc + 2, 32'h0, "post_reset1");
    expect_at(cyc + 3, 32'h0, "post_reset2");

    issue(32'h44000000, 32'h41B40000, 32'h4405A000, "add_534_5");
    issue(32'h43695553, 32'h43543EB8, 32'h43DECA06, "tie_even");
    issue(32'h43E4370A, 32'hC44B1CCD, 32'hC3B20290, "sub_neg");
    issue(32'h00000000, 32'h00000000, 32'h00000000, "zero_after");

    issue(32'h7F800000, 32'hFF800000, 32'h7FC00000, "inf_minus_inf");
    issue(32'h3F800000, 32'hBF800000, 32'h00000000, "x_minus_x");
    issue(32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, "overflow");
    issue(32'h00000001, 32'h3F800000, 32'h3F800000, "denorm_ftz");
    issue(32'hC44B1CCD, 32'h43E4370A, 32'hC3B20290, "commute");
    issue(32'h3F800000, 32'h3F800000, 32'h40000000, "one_plus_one");
    issue(32'h3F800000, 32'h33800000, 32'h3F800000, "tie_down");
    issue(32'h3F800001, 32'h33800000, 32'h3F800002, "tie_odd_up");
    issue(32'h3F800000, 32'h33800001, 32'h3F800001, "above_half");
    issue(32'h3FFFFFFF, 32'h33800000, 32'h40000000, "round_carry");
    issue(32'h3F800000, 32'hBF7FFFFF, 32'h33800000, "cancel");
    issue(32'h00800000, 32'h80800001, 32'h80000000, "underflow");
    issue(32'h80000000, 32'h80000000, 32'h80000000, "neg_zeros");
    issue(32'h80000000, 32'h00000000, 32'h00000000, "mixed_zeros");
    issue(32'h7FC00001, 32'h3F800000, 32'h7FC00000, "nan_in");
    issue(32'h7F800000, 32'h3F800000, 32'h7F800000, "inf_plus_x");
    issue(32'hFF800000, 32'hFF800000, 32'hFF800000, "ninf_ninf");
    issue(32'h00000000, 32'h40490FDB, 32'h40490FDB, "zero_plus_x");

    issue(32'h44000000, 32'h41B40000, 32'h4405A000, "fill0");
    issue(32'h43695553, 32'h43543EB8, 32'h43DECA06, "fill1");
    issue(32'h3F800000, 32'h3F800000, 32'h40000000, "fill2");
    a   = 32'h3F800000;
    b   = 32'h3F800000;
    rst = 1'b1;
    q.delete();
    expect_at(cyc + 1, 32'h0, "rst_mid");
    step();
    rst = 1'b0;
    a   = '0;
    b   = '0;
    expect_at(cyc + 1, 32'h0, "no_stale0");
    expect_at(cyc + 2, 32'h0, "no_stale1");
    expect_at(cyc + 3, 32'h0, "no_stale2");
    issue(32'h00000000, 32'h00000000, 32'h00000000, "no_stale3");
    issue(32'h00000000, 32'h00000000, 32'h00000000, "no_stale4");
    issue(32'h44000000, 32'h41B40000, 32'h4405A000, "restart");
    issue(32'h00000000, 32'h00000000, 32'h00000000, "idle");

    for (int i = 0; i < 20 && q.size() > 0; i++) step();
    if (q.size() > 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
